// File: rtl/fechadura_bloqueio.sv
// Bit-serial N-bit combination lock with consecutive-failure counter and timed lockout.
// Optional macro FECHADURA_PROG_EN adds nova_senha/grava to reprogram the code while open.
module fechadura_bloqueio #(
    parameter int             N               = 6,
    parameter logic [N-1:0]   SENHA_PADRAO    = 6'b101100,
    parameter int             MAX_TENTATIVAS  = 3,
    parameter int             ABERTO_CICLOS   = 8,
    parameter int             BLOQUEIO_CICLOS = 16
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic [N-1:0]                        senha_digitada,
    input  logic                                confirma,
`ifdef FECHADURA_PROG_EN
    input  logic [N-1:0]                        nova_senha,
    input  logic                                grava,
`endif
    output logic                                ledverde,
    output logic                                ledvermelho,
    output logic                                bloqueado,
    output logic                                ocupado,
    output logic [$clog2(MAX_TENTATIVAS+1)-1:0] tentativas
);

    localparam int TW   = $clog2(MAX_TENTATIVAS + 1);
    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam int TMAX = (ABERTO_CICLOS > BLOQUEIO_CICLOS) ? ABERTO_CICLOS : BLOQUEIO_CICLOS;
    localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        FECHADO   = 3'd0,
        CHECA     = 3'd1,
        ABERTO    = 3'd2,
        ERRADO    = 3'd3,
        BLOQUEADO = 3'd4
    } estado_t;

    estado_t         state, state_next;
    logic [N-1:0]    cap;
    logic [N-1:0]    code;
    logic [IW-1:0]   idx;
    logic            flag;
    logic [CW-1:0]   timer;
    logic [TW-1:0]   tent;
    logic [TW-1:0]   tent_inc;
    logic            mismatch_final;
    logic            last;
    logic            lockout;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= FECHADO;
        else          state <= state_next;
    end

    // The verdict on the last bit must include that bit, so the flag is ORed combinationally.
    always_comb begin
        state_next     = state;
        mismatch_final = flag | (cap[idx] ^ code[idx]);
        last           = (idx == IW'(N - 1));
        tent_inc       = tent + TW'(1);
        lockout        = (tent_inc == TW'(MAX_TENTATIVAS));
        case (state)
            FECHADO:   if (confirma) state_next = CHECA;
            CHECA: begin
                if (last) begin
                    if (!mismatch_final) state_next = ABERTO;
                    else if (lockout)    state_next = BLOQUEADO;
                    else                 state_next = ERRADO;
                end
            end
            ABERTO:    if (timer == '0) state_next = FECHADO;
            ERRADO:    state_next = FECHADO;
            BLOQUEADO: if (timer == '0) state_next = FECHADO;
            default:   state_next = FECHADO;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx   <= '0;
            flag  <= 1'b0;
            timer <= '0;
            tent  <= '0;
        end else begin
            case (state)
                FECHADO: begin
                    if (confirma) begin
                        idx  <= '0;
                        flag <= 1'b0;
                    end
                end
                CHECA: begin
                    flag <= mismatch_final;
                    if (!last) begin
                        idx <= idx + IW'(1);
                    end else if (!mismatch_final) begin
                        tent  <= '0;
                        timer <= CW'(ABERTO_CICLOS - 1);
                    end else if (lockout) begin
                        tent  <= TW'(MAX_TENTATIVAS);
                        timer <= CW'(BLOQUEIO_CICLOS - 1);
                    end else begin
                        tent <= tent_inc;
                    end
                end
                ABERTO: begin
                    if (timer != '0) timer <= timer - CW'(1);
                end
                BLOQUEADO: begin
                    if (timer != '0) timer <= timer - CW'(1);
                    else             tent  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Captured copy isolates the check from changes on senha_digitada during CHECA.
    always_ff @(posedge clock) begin
        if (state == FECHADO && confirma) cap <= senha_digitada;
    end

`ifdef FECHADURA_PROG_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                      code <= SENHA_PADRAO;
        else if (state == ABERTO && grava) code <= nova_senha;
    end
`else
    assign code = SENHA_PADRAO;
`endif

    assign ledverde    = (state == ABERTO);
    assign ledvermelho = (state == ERRADO) || (state == BLOQUEADO);
    assign bloqueado   = (state == BLOQUEADO);
    assign ocupado     = (state == CHECA);
    assign tentativas  = tent;

endmodule

// File: doc/fechadura_bloqueio.md
# fechadura_bloqueio

Parametrised successor to the six-bit serial combination lock. It checks an N-bit code bit-serially, one bit per clock, LSB first, and keeps a consecutive-failure counter. After a set number of failed attempts it enters a timed lockout. Sits between the keypad/switch front end and the door LEDs/actuator of the lock subsystem.

## Interface
Parameters:
- N, 6: code width in bits (N ≥ 1)
- SENHA_PADRAO, 6'b101100: reset/default code, N bits
- MAX_TENTATIVAS, 3: consecutive failures that trigger lockout (≥ 1)
- ABERTO_CICLOS, 8: cycles the lock stays open (≥ 1)
- BLOQUEIO_CICLOS, 16: lockout duration in cycles (≥ 1)

Ports:
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- senha_digitada  in  N  entered code, sampled only on accepted confirma
- confirma  in  1  submit pulse; accepted only in FECHADO
- ledverde  out  1  high in ABERTO
- ledvermelho  out  1  high in ERRADO and BLOQUEADO
- bloqueado  out  1  high in BLOQUEADO
- ocupado  out  1  high in CHECA
- tentativas  out  $clog2(MAX_TENTATIVAS+1)  current consecutive-failure count

## Operation
- Reset: state FECHADO, all outputs 0, tentativas 0, bit index 0, mismatch flag 0, code register = SENHA_PADRAO.
- FECHADO: confirma=1 latches senha_digitada into the capture register, clears index and mismatch flag, then goes to CHECA.
- CHECA: each cycle compares captured[idx] against code[idx] and ORs any mismatch into the flag. Index counts 0..N-1. At idx = N-1 the state resolves using the final flag value (including the last bit):
  - match: tentativas ← 0, go to ABERTO.
  - mismatch with tentativas+1 < MAX_TENTATIVAS: tentativas increments, go to ERRADO.
  - mismatch with tentativas+1 = MAX_TENTATIVAS: tentativas ← MAX_TENTATIVAS, go to BLOQUEADO.
- ABERTO: a down-counter loads ABERTO_CICLOS on entry and is held for that many cycles, then goes to FECHADO.
- ERRADO: held exactly 1 cycle, then goes to FECHADO.
- BLOQUEADO: held for BLOQUEIO_CICLOS cycles. On exit, tentativas ← 0 and state goes to FECHADO.
- confirma in any state other than FECHADO is ignored and is not queued.
- senha_digitada changing during CHECA has no effect, because the captured copy is used.
- Outputs are decoded combinationally from state, with a defined value in every state. Unused state encodings return to FECHADO.

## Timing
- confirma accepted at edge t. CHECA occupies edges t+1..t+N. Result state (ABERTO/ERRADO/BLOQUEADO) is visible after edge t+N.
- Total latency from confirma to LED output: N+1 cycles.
- ABERTO: ledverde high for exactly ABERTO_CICLOS cycles.
- BLOQUEADO: ledvermelho and bloqueado high for exactly BLOQUEIO_CICLOS cycles.
- FECHADO can accept a new confirma in the first cycle after returning.
- tentativas updates on the same edge that enters the result state.
- reset_n asserted mid-CHECA, mid-ABERTO or mid-BLOQUEADO: immediate return to reset values, including the lockout timer and the code register.

## Configuration
- Macro FECHADURA_PROG_EN.
- Defined: adds ports nova_senha (in, N) and grava (in, 1).
  - grava=1 while in ABERTO loads nova_senha into the code register at that edge.
  - The new code applies to the next attempt.
  - grava outside ABERTO is ignored.
  - grava on the final ABERTO cycle is still applied.
- Undefined: ports are absent and the code register is the constant SENHA_PADRAO.

## Test plan
Defaults throughout (N=6, SENHA_PADRAO=101100, MAX_TENTATIVAS=3, ABERTO_CICLOS=8, BLOQUEIO_CICLOS=16).
- Correct code: reset, then confirma with 101100 → ocupado high 6 cycles, then ledverde=1 for 8 cycles, tentativas=0, then FECHADO.
- Single wrong bit (MSB): confirma with 001100 → after 7 cycles ledvermelho=1 for 1 cycle, tentativas=1.
- Lockout: three wrong codes (000000, 111111, 101101) → third resolves to BLOQUEADO, bloqueado=1 for 16 cycles with confirma of 101100 ignored throughout, then tentativas=0 and a correct code opens.
- Counter reset on success: two wrong codes then 101100 → ledverde=1, tentativas returns to 0.
- Input isolation and reset: change senha_digitada from 101100 to 000000 during CHECA → still opens; assert reset_n low during ABERTO → ledverde=0 immediately, state FECHADO.
- With FECHADURA_PROG_EN: open, pulse grava with nova_senha=010011 → 101100 now fails and 010011 opens; after reset, 101100 opens again.
